// File: rtl/dmem_responder_if.sv
// Load/store bus between the processor-side wrapper and the memory responder.
// The master drives a request; the slave answers with a one-cycle Ready pulse.
interface dmem_responder_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Err;

  modport master (
    output Req, MemWrite, Addr, WriteData,
    input  ReadData, Ready, Err
  );

  modport slave (
    input  Req, MemWrite, Addr, WriteData,
    output ReadData, Ready, Err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder: word RAM plus an LED/cycle-counter I/O window,
// one request at a time with WAIT_STATES idle cycles before a Ready pulse.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_BASE     = 32'h0000_FF00
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic [7:0]       LEDOut
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] IO_CNT    = IO_BASE + 32'd4;
  localparam int          WCW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (WAIT_STATES > 0) ? WCW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, next_state;
  logic [WCW-1:0]  wait_cnt;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_data;
  logic            cap_write;
  logic [31:0]     cycle_cnt;
  logic [7:0]      led_reg;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            resp;
  logic            hit_ram, hit_led, hit_cnt, bad;
  logic            commit;
  logic [AW-1:0]   ram_idx;
  logic [31:0]     rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.Req) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == WAIT_LAST) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Everything downstream decodes from this captured copy, so the master may
  // change or drop its request freely once it has been accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
    end else if (state == IDLE && bus.Req) begin
      wait_cnt  <= '0;
      cap_addr  <= bus.Addr;
      cap_data  <= bus.WriteData;
      cap_write <= bus.MemWrite;
    end else if (state == WAIT) begin
      wait_cnt  <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_comb begin
    resp    = (state == RESP);
    hit_ram = (cap_addr[1:0] == 2'b00) && (cap_addr < RAM_BYTES);
    hit_led = (cap_addr == IO_BASE);
    hit_cnt = (cap_addr == IO_CNT);
    bad     = !(hit_ram || hit_led || hit_cnt) || (hit_cnt && cap_write);
    ram_idx = cap_addr[AW+1:2];
    commit  = resp && cap_write && !bad;
  end

  always_comb begin
    rd_word = '0;
    if (hit_ram) begin
      rd_word = mem[ram_idx];
    end else if (hit_led) begin
      rd_word = {24'b0, led_reg};
    end else if (hit_cnt) begin
      rd_word = cycle_cnt;
    end
  end

  // Stores land on the edge that ends RESP; an async reset pulls the FSM out
  // of RESP first, so an aborted store can never reach the RAM or LEDs.
  always_ff @(posedge clk) begin
    if (commit && hit_ram) begin
      mem[ram_idx] <= cap_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg <= '0;
    end else if (commit && hit_led) begin
      led_reg <= cap_data[7:0];
    end
  end

  assign bus.Ready    = resp;
  assign bus.Err      = resp && bad;
  assign bus.ReadData = (resp && !cap_write && !bad) ? rd_word : 32'h0;
  assign LEDOut       = led_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one DUT with default wait states and
// one with zero wait states, sharing clock, reset and stimulus.
module tb_dmem_responder;

  localparam logic [31:0] IO_BASE = 32'h0000_FF00;
  localparam logic [31:0] JUNK    = 32'h0000_8004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        mem_write = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  led, ledz;
  logic        rdy, err_w;
  logic [31:0] rdata_w;
  logic [7:0]  led_w;
  logic [31:0] cyc_count;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if busz ();

  assign bus.Req        = req & ~sel;
  assign bus.MemWrite   = mem_write;
  assign bus.Addr       = addr;
  assign bus.WriteData  = wdata;
  assign busz.Req       = req & sel;
  assign busz.MemWrite  = mem_write;
  assign busz.Addr      = addr;
  assign busz.WriteData = wdata;

  assign rdy     = sel ? busz.Ready    : bus.Ready;
  assign err_w   = sel ? busz.Err      : bus.Err;
  assign rdata_w = sel ? busz.ReadData : bus.ReadData;
  assign led_w   = sel ? ledz          : led;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .LEDOut(led)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .IO_BASE(IO_BASE)) dutz (
    .clk(clk), .reset(reset), .bus(busz.slave), .LEDOut(ledz)
  );

  // Reference count of clock edges since reset released.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc_count = 0;
    else       cyc_count = cyc_count + 1;
  end

  // One request: accepted on the next edge, then inputs scrambled while waiting.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er,
                       output logic stray, output logic [7:0] led_resp);
    lat = -1; rd = '0; er = 1'b0; stray = 1'b0; led_resp = '0;
    @(negedge clk);
    mem_write = wr; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; mem_write = ~wr; addr = JUNK; wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rdy) begin
        lat = i; rd = rdata_w; er = err_w; led_resp = led_w;
        break;
      end
      if (err_w || rdata_w != 32'h0) stray = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic er, st; logic [7:0] lr; exp_t e;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy, err_w, rdata_w, led} !== {1'b0, 1'b0, 32'h0, 8'h0}) begin
      failures++;
      $display("[TB] FAIL reset_idle got ready=%b err=%b data=%h led=%h want all zero",
               rdy, err_w, rdata_w, led);
    end
    sbq.push_back('{cyc_count + 32'd3, 1'b0, 3});
    issue(1'b0, IO_BASE + 32'd4, 32'h0, lat, rd, er, st, lr);
    e = sbq.pop_front();
    checks++;
    if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
      failures++;
      $display("[TB] FAIL counter_after_reset got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
               lat, st, er, rd, e.lat, e.err, e.data);
    end
  endtask

  task automatic test_ram();
    int lat; logic [31:0] rd; logic er, st; logic [7:0] lr; exp_t e;
    logic        wr_t   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] addr_t [5] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h14};
    logic [31:0] data_t [5] = '{32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D, 32'h0, 32'h5555_AAAA};
    logic [31:0] exp_t_ [5] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D, 32'h0};
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sbq.push_back('{exp_t_[i], 1'b0, 3});
      issue(wr_t[i], addr_t[i], data_t[i], lat, rd, er, st, lr);
      e = sbq.pop_front();
      checks++;
      if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
        failures++;
        $display("[TB] FAIL ram_%0d got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
                 i, lat, st, er, rd, e.lat, e.err, e.data);
      end
    end
    sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{(i == 0) ? 32'h0 : 32'hCAFE_F00D, 1'b0, 1});
      issue(i == 0, 32'h10, 32'hCAFE_F00D, lat, rd, er, st, lr);
      e = sbq.pop_front();
      checks++;
      if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
        failures++;
        $display("[TB] FAIL ram_nowait_%0d got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
                 i, lat, st, er, rd, e.lat, e.err, e.data);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_led();
    int lat; logic [31:0] rd; logic er, st; logic [7:0] lr; exp_t e;
    sbq.push_back('{32'h0, 1'b0, 3});
    issue(1'b1, IO_BASE, 32'h0000_01A5, lat, rd, er, st, lr);
    e = sbq.pop_front();
    checks++;
    if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
      failures++;
      $display("[TB] FAIL led_store got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
               lat, st, er, rd, e.lat, e.err, e.data);
    end
    checks++;
    if ({lr, led} !== {8'h00, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL led_commit got during_resp=%h after=%h want 00 then a5", lr, led);
    end
    sbq.push_back('{32'h0000_00A5, 1'b0, 3});
    issue(1'b0, IO_BASE, 32'h0, lat, rd, er, st, lr);
    e = sbq.pop_front();
    checks++;
    if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
      failures++;
      $display("[TB] FAIL led_load got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
               lat, st, er, rd, e.lat, e.err, e.data);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, st; logic [7:0] lr; exp_t e;
    logic        wr_t   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] addr_t [6] = '{32'h13, 32'h0000_8000, IO_BASE + 32'd4, IO_BASE + 32'd4, 32'h10, 32'h12};
    logic        err_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      if (i == 3)      sbq.push_back('{cyc_count + 32'd3, 1'b0, 3});
      else if (i == 4) sbq.push_back('{32'hDEAD_BEEF, 1'b0, 3});
      else             sbq.push_back('{32'h0, err_t[i], 3});
      issue(wr_t[i], addr_t[i], 32'h1111_2222, lat, rd, er, st, lr);
      e = sbq.pop_front();
      checks++;
      if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
        failures++;
        $display("[TB] FAIL err_%0d got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
                 i, lat, st, er, rd, e.lat, e.err, e.data);
      end
    end
    checks++;
    if (led !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL err_led got %h want a5", led);
    end
  endtask

  // Req held high: next target is presented at RESP, junk once the accept is past.
  task automatic test_back_to_back();
    logic [31:0] targets [2] = '{32'h10, IO_BASE};
    logic [31:0] values  [2] = '{32'hDEAD_BEEF, 32'h0000_00A5};
    int k, got, t, last_t;
    exp_t e;
    sel = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    addr = targets[0];
    sbq.push_back('{values[0], 1'b0, 0});
    req = 1'b1; k = 1; got = 0; t = 0; last_t = -1;
    while (got < 4 && t < 60) begin
      @(negedge clk);
      t++; k++;
      if (rdy) begin
        e = sbq.pop_front();
        checks++;
        if ({err_w, rdata_w} !== {e.err, e.data}) begin
          failures++;
          $display("[TB] FAIL b2b_data_%0d got err=%b data=%h want err=%b data=%h",
                   got, err_w, rdata_w, e.err, e.data);
        end
        if (last_t >= 0) begin
          checks++;
          if (t - last_t !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_spacing_%0d got %0d cycles want 4", got, t - last_t);
          end
        end
        last_t = t; got++; k = 0;
        if (got < 4) begin
          addr = targets[got % 2];
          sbq.push_back('{values[got % 2], 1'b0, 0});
        end else begin
          req = 1'b0;
        end
      end else if (k >= 2) begin
        addr = 32'h0000_8000;
      end
    end
    req = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("[TB] FAIL b2b_count got %0d responses want 4", got);
    end
    sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, st; logic [7:0] lr; exp_t e;
    logic seen;
    sel = 1'b0;
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy || err_w) seen = 1'b1;
      if (i == 2) reset = 1'b0;
    end
    checks++;
    if ({seen, led} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL abort_ready got ready_seen=%b led=%h want 0 and 00", seen, led);
    end
    @(posedge clk);
    #1;
    sbq.push_back('{cyc_count + 32'd3, 1'b0, 3});
    issue(1'b0, IO_BASE + 32'd4, 32'h0, lat, rd, er, st, lr);
    e = sbq.pop_front();
    checks++;
    if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
      failures++;
      $display("[TB] FAIL abort_counter got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
               lat, st, er, rd, e.lat, e.err, e.data);
    end
    sbq.push_back('{32'h0BAD_F00D, 1'b0, 3});
    issue(1'b0, 32'h20, 32'h0, lat, rd, er, st, lr);
    e = sbq.pop_front();
    checks++;
    if ({8'(lat), st, er, rd} !== {8'(e.lat), 1'b0, e.err, e.data}) begin
      failures++;
      $display("[TB] FAIL abort_ram got lat=%0d stray=%b err=%b data=%h want lat=%0d err=%b data=%h",
               lat, st, er, rd, e.lat, e.err, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
